iter_shift_unit: RTL and testbench
==================================

# iter_shift_unit

Multi-cycle shift/rotate unit for the MCU execute stage, parametrised in operand width and bits shifted per cycle. It accepts an operand, opcode and shift amount via a ready/enable handshake. It iterates in chunks of up to STEP bits per cycle and holds the result, carry and zero flags with a one-cycle done pulse. It adds rotates, carry-out, back-to-back issue and illegal-op flagging.

## Interface
- OP_SZ, 32, operand width; power of 2, ≥ 8
- STEP, 1, maximum bits shifted per cycle; power of 2, 1 ≤ STEP ≤ OP_SZ/2
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high; one clock domain, reset asynchronous active-high
- en  input  1  start request; accepted only while ready=1
- op  input  4  opcode: 9 LSL, 10 LSR, 11 ASR, 12 ROL, 13 ROR; others illegal
- data  input  OP_SZ  operand
- shift_value  input  $clog2(OP_SZ)  shift amount, 0..OP_SZ-1
- ready  output  1  unit can accept en this cycle
- out  output  OP_SZ  result, held until next accept
- carry  output  1  last bit shifted/rotated out
- zero  output  1  out == 0
- illegal  output  1  last accepted op was not 9..13
- op_done  output  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT, DONE, encoded as 2 bits.
- Reset (any time, including mid-operation) forces IDLE with out=0, carry=0, zero=1, illegal=0, op_done=0, ready=1, and remaining count 0. An in-flight operation is discarded.
- ready=1 in IDLE and DONE, 0 in SHIFT. en with ready=0 is ignored; there is no queue.
- On accept, register data, op and shift_value. Clear carry. Set illegal from op.
  - If shift_value=0 or op is illegal, go to DONE, with out=data and carry=0.
  - Otherwise go to SHIFT with remaining=shift_value.
- SHIFT: each cycle apply amt=min(STEP, remaining) and subtract amt from remaining. When remaining reaches 0, go to DONE.
  - LSL fills zeros at the LSB. LSR fills zeros at the MSB. ASR replicates the MSB. ROL/ROR wrap.
  - carry takes the last bit leaving the word in that step. For LSL/ROL this is bit OP_SZ-amt of the pre-step value. For LSR/ASR/ROR it is bit amt-1.
- DONE: op_done=1 for this cycle only. out, carry, zero and illegal stay held until the next accept.
  - en in DONE is accepted, giving back-to-back operation.
  - Without en, go to IDLE.
- op is sampled only at accept; changes to the inputs during SHIFT have no effect.
- zero is derived from the registered out in every state.

## Timing
- Accept at edge k. op_done is high during cycle k+N+1, where N=ceil(shift_value/STEP), with N=0 for a zero amount or illegal op.
- out, carry and zero are final on the same edge that raises op_done.
- Back-to-back: en in the DONE cycle gives the next op_done at k'+N'+1 with no idle bubble.
- STEP=1 matches the legacy one-bit-per-cycle timing plus the DONE cycle.
- Asynchronous reset asserted mid-SHIFT clears everything immediately. Release is synchronised by the system reset tree.

## Structure
- Package mcu_shift_pkg holds:
  - the opcode constants OP_LSL=9, OP_LSR=10, OP_ASR=11, OP_ROL=12, OP_ROR=13
  - the state encoding IDLE/SHIFT/DONE
  - the function is_shift_op(op)
- One sub-module, shift_step. It is a combinational shift by a variable amount 0..STEP, returning the next value and the carry bit. It is instantiated once.
- The top level holds the FSM, the remaining-count register, the result register and the flags.

## Test plan
- Reset mid-operation: OP_SZ=32, STEP=4, LSL 0x1 by 31, assert reset at cycle 3. Required: out=0, ready=1, op_done never pulses. Repeat without reset: op_done at k+9, out=0x80000000, carry=0, zero=0.
- ASR: 0x80000010 by 5, STEP=4. Required: op_done at k+3, out=0xFC000000, carry=1.
- LSR: 0x0000000F by 4, STEP=4. Required: op_done at k+2, out=0, carry=1, zero=1.
- ROR then ROL back-to-back, STEP=4:
  - ROR 0x12345678 by 8 gives 0x78123456, carry=0.
  - en in its DONE cycle with ROL 0x80000001 by 1 gives 0x00000003, carry=1, op_done 2 cycles later.
- Zero amount and illegal op:
  - shift_value=0, op=9, data=0xA5 gives op_done at k+1, out=0xA5, carry=0, illegal=0.
  - op=4 gives op_done at k+1, out=data, illegal=1.
  - en asserted while ready=0 is ignored and state is unchanged.
- STEP=1 sweep of all 5 ops × amounts 0..31 against a reference model: results, carry and latency N+1 all match.

Source files
------------

// File: rtl/iter_shift_unit_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality check for the
// iterative shift/rotate unit.
package mcu_shift_pkg;

   localparam logic [3:0] OP_LSL = 4'd9;
   localparam logic [3:0] OP_LSR = 4'd10;
   localparam logic [3:0] OP_ASR = 4'd11;
   localparam logic [3:0] OP_ROL = 4'd12;
   localparam logic [3:0] OP_ROR = 4'd13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift_op(input logic [3:0] op);
      return (op >= OP_LSL) && (op <= OP_ROR);
   endfunction

endpackage

// File: rtl/iter_shift_unit_if.sv
// Issue/result bundle between the execute stage and the shift unit.
// The master drives the request; the slave returns status and result.
interface iter_shift_unit_if #(
   parameter int OP_SZ = 32
) ();
   logic                     en;
   logic [3:0]               op;
   logic [OP_SZ-1:0]         data;
   logic [$clog2(OP_SZ)-1:0] shift_value;
   logic                     ready;
   logic [OP_SZ-1:0]         out;
   logic                     carry;
   logic                     zero;
   logic                     illegal;
   logic                     op_done;

   modport master (
      output en, op, data, shift_value,
      input  ready, out, carry, zero, illegal, op_done
   );

   modport slave (
      input  en, op, data, shift_value,
      output ready, out, carry, zero, illegal, op_done
   );
endinterface

// File: rtl/iter_shift_unit_step.sv
// One iteration of the shifter: shift/rotate by 0..STEP bits, combinational,
// returning the next word and the last bit that left it.
module shift_step
   import mcu_shift_pkg::*;
#(
   parameter int OP_SZ = 32,
   parameter int STEP  = 1,
   localparam int AW   = $clog2(STEP) + 1,
   localparam int IW   = $clog2(OP_SZ)
) (
   input  logic [OP_SZ-1:0] val,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    amt,
   output logic [OP_SZ-1:0] nxt,
   output logic             cout
);

   int          sh;
   logic [IW-1:0] lidx;
   logic [IW-1:0] ridx;

   always_comb begin
      sh   = int'(amt);
      // lidx doubles as the complementary rotate distance; it wraps to 0 when amt is 0
      lidx = IW'(OP_SZ - sh);
      ridx = IW'(sh - 1);
      nxt  = val;
      cout = 1'b0;
      case (op)
         OP_LSL: begin
            nxt  = val << amt;
            cout = val[lidx];
         end
         OP_LSR: begin
            nxt  = val >> amt;
            cout = val[ridx];
         end
         OP_ASR: begin
            nxt  = $signed(val) >>> amt;
            cout = val[ridx];
         end
         OP_ROL: begin
            nxt  = (val << amt) | (val >> lidx);
            cout = val[lidx];
         end
         OP_ROR: begin
            nxt  = (val >> amt) | (val << lidx);
            cout = val[ridx];
         end
         default: begin
            nxt  = val;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP bits per cycle, result held with a
// one-cycle op_done; ready drops only while shifting, en while busy is dropped.
module iter_shift_unit
   import mcu_shift_pkg::*;
#(
   parameter int OP_SZ = 32,
   parameter int STEP  = 1,
   localparam int AW   = $clog2(STEP) + 1,
   localparam int IW   = $clog2(OP_SZ)
) (
   input  logic              clk,
   input  logic              reset,
   iter_shift_unit_if.slave  bus
);

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    rem;
   logic [OP_SZ-1:0] out_r;
   logic             carry_r;
   logic             illegal_r;
   logic [3:0]       op_r;
   logic [AW-1:0]    amt;
   logic [OP_SZ-1:0] step_val;
   logic             step_cout;
   logic             accept;
   logic             start_shift;

   assign accept      = bus.en && (state != SHIFT);
   assign start_shift = is_shift_op(bus.op) && (bus.shift_value != '0);
   assign amt         = (rem >= IW'(STEP)) ? AW'(STEP) : AW'(rem);

   shift_step #(
      .OP_SZ (OP_SZ),
      .STEP  (STEP)
   ) u_step (
      .val  (out_r),
      .op   (op_r),
      .amt  (amt),
      .nxt  (step_val),
      .cout (step_cout)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = start_shift ? SHIFT : DONE;
         end
         SHIFT: begin
            if (rem == IW'(amt)) state_nxt = DONE;
         end
         DONE: begin
            if (accept) state_nxt = start_shift ? SHIFT : DONE;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_r     <= '0;
         carry_r   <= 1'b0;
         illegal_r <= 1'b0;
         op_r      <= '0;
         rem       <= '0;
      end else if (accept) begin
         out_r     <= bus.data;
         carry_r   <= 1'b0;
         illegal_r <= !is_shift_op(bus.op);
         op_r      <= bus.op;
         rem       <= start_shift ? bus.shift_value : '0;
      end else if (state == SHIFT) begin
         out_r     <= step_val;
         carry_r   <= step_cout;
         rem       <= rem - IW'(amt);
      end
   end

   assign bus.ready   = (state != SHIFT);
   assign bus.out     = out_r;
   assign bus.carry   = carry_r;
   assign bus.zero    = (out_r == '0);
   assign bus.illegal = illegal_r;
   assign bus.op_done = (state == DONE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench: STEP=4 instance for scenario tests, STEP=1 instance for a
// full opcode x amount sweep against a bit-serial reference.
module tb_iter_shift_unit;

   localparam logic [3:0] LSL = 4'd9;
   localparam logic [3:0] LSR = 4'd10;
   localparam logic [3:0] ASR = 4'd11;
   localparam logic [3:0] ROL = 4'd12;
   localparam logic [3:0] ROR = 4'd13;

   logic clk = 1'b0;
   logic reset4 = 1'b1;
   logic reset1 = 1'b1;
   int   applied = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   iter_shift_unit_if #(.OP_SZ(32)) bus4 ();
   iter_shift_unit_if #(.OP_SZ(32)) bus1 ();

   iter_shift_unit #(.OP_SZ(32), .STEP(4)) dut4 (.clk(clk), .reset(reset4), .bus(bus4));
   iter_shift_unit #(.OP_SZ(32), .STEP(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

   // Issue one op on the STEP=4 unit; lat = edges from accept edge until op_done is seen.
   task automatic go4(input logic [3:0] o, input logic [31:0] d, input logic [4:0] s,
                      output int lat);
      @(negedge clk);
      bus4.en = 1'b1; bus4.op = o; bus4.data = d; bus4.shift_value = s;
      @(posedge clk); #1;
      bus4.en = 1'b0;
      lat = 0;
      while (bus4.op_done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic go1(input logic [3:0] o, input logic [31:0] d, input logic [4:0] s,
                      output int lat);
      @(negedge clk);
      bus1.en = 1'b1; bus1.op = o; bus1.data = d; bus1.shift_value = s;
      @(posedge clk); #1;
      bus1.en = 1'b0;
      lat = 0;
      while (bus1.op_done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic ref_model(input logic [3:0] o, input logic [31:0] d, input int s,
                            output logic [31:0] r, output logic c);
      r = d;
      c = 1'b0;
      for (int i = 0; i < s; i++) begin
         case (o)
            LSL: begin c = r[31]; r = {r[30:0], 1'b0};  end
            LSR: begin c = r[0];  r = {1'b0, r[31:1]};  end
            ASR: begin c = r[0];  r = {r[31], r[31:1]}; end
            ROL: begin c = r[31]; r = {r[30:0], r[31]}; end
            ROR: begin c = r[0];  r = {r[0], r[31:1]};  end
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      #1;
      applied++; if (bus4.out !== 32'h0)  begin miscompares++; $display("FAIL reset_out got %h want 0", bus4.out); end
      applied++; if (bus4.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus4.ready); end
      applied++; if (bus4.zero !== 1'b1)  begin miscompares++; $display("FAIL reset_zero got %b want 1", bus4.zero); end
      applied++; if ({bus4.carry, bus4.illegal, bus4.op_done} !== 3'b000)
         begin miscompares++; $display("FAIL reset_flags got %b want 000", {bus4.carry, bus4.illegal, bus4.op_done}); end
      applied++; if ({bus1.out, bus1.zero, bus1.ready, bus1.op_done} !== {32'h0, 3'b110})
         begin miscompares++; $display("FAIL reset_step1 got %h/%b%b%b want 0/110", bus1.out, bus1.zero, bus1.ready, bus1.op_done); end
   endtask

   task automatic test_reset_mid_op();
      bit seen = 1'b0;
      @(negedge clk);
      bus4.en = 1'b1; bus4.op = LSL; bus4.data = 32'h1; bus4.shift_value = 5'd31;
      @(posedge clk); #1;
      bus4.en = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      applied++; if (bus4.ready !== 1'b0) begin miscompares++; $display("FAIL midrst_busy ready got %b want 0", bus4.ready); end
      #2 reset4 = 1'b1;
      #1;
      applied++; if (bus4.out !== 32'h0)  begin miscompares++; $display("FAIL midrst_out got %h want 0", bus4.out); end
      applied++; if (bus4.ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", bus4.ready); end
      applied++; if (bus4.zero !== 1'b1)  begin miscompares++; $display("FAIL midrst_zero got %b want 1", bus4.zero); end
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus4.op_done === 1'b1) seen = 1'b1;
         if (i == 3) reset4 = 1'b0;
      end
      applied++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done got %b want 0", seen); end
      applied++; if (bus4.out !== 32'h0) begin miscompares++; $display("FAIL midrst_after got %h want 0", bus4.out); end
   endtask

   task automatic test_lsl_full();
      int lat;
      go4(LSL, 32'h1, 5'd31, lat);
      applied++; if (lat !== 8) begin miscompares++; $display("FAIL lsl31_lat got %0d want 8", lat); end
      applied++; if (bus4.out !== 32'h80000000) begin miscompares++; $display("FAIL lsl31_out got %h want 80000000", bus4.out); end
      applied++; if ({bus4.carry, bus4.zero, bus4.illegal} !== 3'b000)
         begin miscompares++; $display("FAIL lsl31_flags got %b want 000", {bus4.carry, bus4.zero, bus4.illegal}); end
   endtask

   task automatic test_asr();
      int lat;
      go4(ASR, 32'h80000010, 5'd5, lat);
      applied++; if (lat !== 2) begin miscompares++; $display("FAIL asr_lat got %0d want 2", lat); end
      applied++; if (bus4.out !== 32'hFC000000) begin miscompares++; $display("FAIL asr_out got %h want fc000000", bus4.out); end
      applied++; if (bus4.carry !== 1'b1) begin miscompares++; $display("FAIL asr_carry got %b want 1", bus4.carry); end
   endtask

   task automatic test_lsr();
      int lat;
      go4(LSR, 32'h0000000F, 5'd4, lat);
      applied++; if (lat !== 1) begin miscompares++; $display("FAIL lsr_lat got %0d want 1", lat); end
      applied++; if (bus4.out !== 32'h0) begin miscompares++; $display("FAIL lsr_out got %h want 0", bus4.out); end
      applied++; if ({bus4.carry, bus4.zero} !== 2'b11) begin miscompares++; $display("FAIL lsr_flags got %b want 11", {bus4.carry, bus4.zero}); end
   endtask

   task automatic test_back_to_back();
      int lat;
      go4(ROR, 32'h12345678, 5'd8, lat);
      applied++; if (lat !== 2) begin miscompares++; $display("FAIL ror_lat got %0d want 2", lat); end
      applied++; if (bus4.out !== 32'h78123456) begin miscompares++; $display("FAIL ror_out got %h want 78123456", bus4.out); end
      applied++; if (bus4.carry !== 1'b0) begin miscompares++; $display("FAIL ror_carry got %b want 0", bus4.carry); end
      // issued from inside the DONE cycle just observed
      go4(ROL, 32'h80000001, 5'd1, lat);
      applied++; if (lat !== 1) begin miscompares++; $display("FAIL rol_b2b_lat got %0d want 1", lat); end
      applied++; if (bus4.out !== 32'h00000003) begin miscompares++; $display("FAIL rol_out got %h want 00000003", bus4.out); end
      applied++; if (bus4.carry !== 1'b1) begin miscompares++; $display("FAIL rol_carry got %b want 1", bus4.carry); end
   endtask

   task automatic test_zero_illegal();
      int lat;
      go4(LSL, 32'h000000A5, 5'd0, lat);
      applied++; if (lat !== 0) begin miscompares++; $display("FAIL zamt_lat got %0d want 0", lat); end
      applied++; if (bus4.out !== 32'hA5) begin miscompares++; $display("FAIL zamt_out got %h want a5", bus4.out); end
      applied++; if ({bus4.carry, bus4.illegal} !== 2'b00) begin miscompares++; $display("FAIL zamt_flags got %b want 00", {bus4.carry, bus4.illegal}); end
      go4(4'd4, 32'h00001234, 5'd3, lat);
      applied++; if (lat !== 0) begin miscompares++; $display("FAIL illeg_lat got %0d want 0", lat); end
      applied++; if (bus4.out !== 32'h1234) begin miscompares++; $display("FAIL illeg_out got %h want 1234", bus4.out); end
      applied++; if ({bus4.illegal, bus4.carry} !== 2'b10) begin miscompares++; $display("FAIL illeg_flags got %b want 10", {bus4.illegal, bus4.carry}); end
   endtask

   task automatic test_busy_ignored();
      int lat;
      @(negedge clk);
      bus4.en = 1'b1; bus4.op = LSL; bus4.data = 32'h1; bus4.shift_value = 5'd31;
      @(posedge clk); #1;
      applied++; if (bus4.ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready got %b want 0", bus4.ready); end
      bus4.op = ROR; bus4.data = 32'hFFFFFFFF; bus4.shift_value = 5'd3;
      lat = 0;
      while (bus4.op_done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 3) bus4.en = 1'b0;
      end
      bus4.en = 1'b0;
      applied++; if (lat !== 8) begin miscompares++; $display("FAIL busy_lat got %0d want 8", lat); end
      applied++; if (bus4.out !== 32'h80000000) begin miscompares++; $display("FAIL busy_out got %h want 80000000", bus4.out); end
      @(posedge clk); #1;
      applied++; if ({bus4.op_done, bus4.ready} !== 2'b01) begin miscompares++; $display("FAIL idle_after got %b want 01", {bus4.op_done, bus4.ready}); end
      applied++; if (bus4.out !== 32'h80000000) begin miscompares++; $display("FAIL idle_hold got %h want 80000000", bus4.out); end
   endtask

   task automatic test_step1_sweep();
      int          lat;
      logic [31:0] d;
      logic [31:0] r;
      logic        c;
      logic [3:0]  o;
      for (int oi = 0; oi < 5; oi++) begin
         o = LSL + 4'(oi);
         for (int s = 0; s < 32; s++) begin
            d = 32'h8D3CA5F1 + 32'(s) * 32'h01234567;
            ref_model(o, d, s, r, c);
            go1(o, d, 5'(s), lat);
            applied++; if (bus1.out !== r) begin miscompares++; $display("FAIL sweep_out op=%0d s=%0d got %h want %h", o, s, bus1.out, r); end
            applied++; if (bus1.carry !== c) begin miscompares++; $display("FAIL sweep_carry op=%0d s=%0d got %b want %b", o, s, bus1.carry, c); end
            applied++; if (bus1.zero !== (r == 32'h0)) begin miscompares++; $display("FAIL sweep_zero op=%0d s=%0d got %b", o, s, bus1.zero); end
            applied++; if (lat !== s) begin miscompares++; $display("FAIL sweep_lat op=%0d s=%0d got %0d want %0d", o, s, lat, s); end
         end
      end
      go1(ROL, 32'h0, 5'd0, lat);
      applied++; if ({bus1.zero, bus1.illegal} !== 2'b10) begin miscompares++; $display("FAIL sweep_zero0 got %b want 10", {bus1.zero, bus1.illegal}); end
   endtask

   initial begin
      bus4.en = 1'b0; bus4.op = 4'd0; bus4.data = 32'h0; bus4.shift_value = 5'd0;
      bus1.en = 1'b0; bus1.op = 4'd0; bus1.data = 32'h0; bus1.shift_value = 5'd0;
      repeat (3) @(posedge clk);
      test_reset();
      @(negedge clk);
      reset4 = 1'b0;
      reset1 = 1'b0;
      test_reset_mid_op();
      test_lsl_full();
      test_asr();
      test_lsr();
      test_back_to_back();
      test_zero_illegal();
      test_busy_ignored();
      test_step1_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
